// File: rtl/led_pattern_gen.sv
// Prescaled LED pattern generator: binary count, bouncing scanner, PWM and (optional) breathe.
// Mode 3 breathe logic exists only when LED_PATTERN_BREATHE_EN is defined; otherwise mode 3 drives led=0.
module led_pattern_gen #(
  parameter int N_LED     = 8,
  parameter int PRESC_DIV = 262144
) (
  input  logic             clk0,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [7:0]       duty,
  output logic [N_LED-1:0] led,
  output logic             tick
);

  localparam int PSW  = $clog2(PRESC_DIV);
  localparam int POSW = (N_LED > 1) ? $clog2(N_LED) : 1;
  localparam logic [PSW-1:0]  PMAX    = PSW'(PRESC_DIV - 1);
  localparam logic [POSW-1:0] POS_TOP = POSW'(N_LED - 1);

  typedef enum logic [1:0] {
    MODE_BIN     = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_PWM     = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  logic [PSW-1:0]   presc;
  mode_t            mode_q;
  logic [N_LED-1:0] count;
  logic [POSW-1:0]  pos;
  dir_t             dir;
  logic [7:0]       pwm_cnt;
  logic [7:0]       duty_q;

  logic             mode_chg;
  logic             presc_wrap;
  logic             step;
  logic [POSW-1:0]  pos_nxt;
  dir_t             dir_nxt;
  logic [7:0]       pwm_duty;
  logic [N_LED-1:0] scan_led;
  logic [N_LED-1:0] led_nxt;

  // A mode change wins over a coincident tick: the cycle only clears.
  assign mode_chg   = en && (mode_t'(mode) != mode_q);
  assign presc_wrap = (presc == PMAX);
  assign step       = en && presc_wrap && !mode_chg;

  // New duty is picked up only at the start of a PWM period.
  assign pwm_duty = (pwm_cnt == 8'd0) ? duty : duty_q;
  assign scan_led = N_LED'(1) << pos;

  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (N_LED > 1) begin
      if (dir == DIR_UP) begin
        if (pos == POS_TOP) begin
          dir_nxt = DIR_DOWN;
          pos_nxt = pos - 1'b1;
        end else begin
          pos_nxt = pos + 1'b1;
        end
      end else begin
        if (pos == '0) begin
          dir_nxt = DIR_UP;
          pos_nxt = pos + 1'b1;
        end else begin
          pos_nxt = pos - 1'b1;
        end
      end
    end
  end

`ifdef LED_PATTERN_BREATHE_EN
  logic [7:0] br_duty;
  dir_t       br_dir;

  always_ff @(posedge clk0) begin
    if (!rst) begin
      br_duty <= 8'd0;
      br_dir  <= DIR_UP;
    end else if (mode_chg) begin
      br_duty <= 8'd0;
      br_dir  <= DIR_UP;
    end else if (step && mode_q == MODE_BREATHE) begin
      if (br_dir == DIR_UP) begin
        if (br_duty == 8'hFF) begin
          br_dir  <= DIR_DOWN;
          br_duty <= 8'hFE;
        end else begin
          br_duty <= br_duty + 8'd1;
        end
      end else begin
        if (br_duty == 8'd0) begin
          br_dir  <= DIR_UP;
          br_duty <= 8'd1;
        end else begin
          br_duty <= br_duty - 8'd1;
        end
      end
    end
  end
`endif

  always_comb begin
    led_nxt = '0;
    case (mode_q)
      MODE_BIN:  led_nxt = count;
      MODE_SCAN: led_nxt = scan_led;
      MODE_PWM:  led_nxt = {N_LED{pwm_cnt < pwm_duty}};
      MODE_BREATHE: begin
`ifdef LED_PATTERN_BREATHE_EN
        led_nxt = {N_LED{pwm_cnt < br_duty}};
`else
        led_nxt = '0;
`endif
      end
      default: led_nxt = '0;
    endcase
  end

  always_ff @(posedge clk0) begin
    if (!rst) begin
      presc   <= '0;
      mode_q  <= MODE_BIN;
      count   <= '0;
      pos     <= '0;
      dir     <= DIR_UP;
      pwm_cnt <= 8'd0;
      duty_q  <= 8'd0;
      led     <= '0;
      tick    <= 1'b0;
    end else if (en) begin
      tick    <= step;
      led     <= led_nxt;
      pwm_cnt <= pwm_cnt + 8'd1;
      if (pwm_cnt == 8'd0) begin
        duty_q <= duty;
      end
      if (mode_chg) begin
        mode_q <= mode_t'(mode);
        presc  <= '0;
        count  <= '0;
        pos    <= '0;
        dir    <= DIR_UP;
      end else begin
        presc <= presc_wrap ? '0 : presc + 1'b1;
        if (step) begin
          case (mode_q)
            MODE_BIN: count <= count + 1'b1;
            MODE_SCAN: begin
              pos <= pos_nxt;
              dir <= dir_nxt;
            end
            default: ;
          endcase
        end
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Bench for led_pattern_gen: tick-count based reference model checked every cycle, plus directed literals.
module tb_led_pattern_gen;
  localparam int N  = 4;
  localparam int PD = 4;

  logic         clk0 = 1'b0;
  logic         rst  = 1'b0;
  logic         en   = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [7:0]   duty = 8'd0;
  logic [N-1:0] led;
  logic         tick;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk0 = ~clk0;

  led_pattern_gen #(.N_LED(N), .PRESC_DIV(PD)) dut (
    .clk0 (clk0),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .duty (duty),
    .led  (led),
    .tick (tick)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: pattern is a closed-form function of ticks elapsed since the last clear.
  int           m_presc, m_ticks, m_pwm, m_dutyq;
  logic [1:0]   m_mode;
  logic [N-1:0] e_led;
  logic         e_tick;
  bit           model_ok = 1'b0;

  function automatic logic [N-1:0] pattern(input logic [1:0] md, input int t, input int pc, input int d);
    int per, p, ps, bd;
    case (md)
      2'd0: return N'(t);
      2'd1: begin
        if (N == 1) return N'(1);
        per = 2 * (N - 1);
        p   = t % per;
        ps  = (p < N) ? p : per - p;
        return N'(1 << ps);
      end
      2'd2: return (pc < d) ? '1 : '0;
      default: begin
`ifdef LED_PATTERN_BREATHE_EN
        p  = t % 510;
        bd = (p <= 255) ? p : 510 - p;
        return (pc < bd) ? '1 : '0;
`else
        p  = t;
        bd = d;
        return '0;
`endif
      end
    endcase
  endfunction

  always @(posedge clk0) begin
    logic [N-1:0] nl;
    int           eff;
    if (!rst) begin
      m_presc = 0; m_ticks = 0; m_pwm = 0; m_dutyq = 0; m_mode = 2'd0;
      e_led = '0; e_tick = 1'b0; model_ok = 1'b1;
    end else if (en) begin
      eff = (m_pwm == 0) ? int'(duty) : m_dutyq;
      nl  = pattern(m_mode, m_ticks, m_pwm, eff);
      if (mode != m_mode) begin
        m_mode = mode; m_presc = 0; m_ticks = 0; e_tick = 1'b0;
      end else if (m_presc == PD - 1) begin
        m_presc = 0; m_ticks++; e_tick = 1'b1;
      end else begin
        m_presc++; e_tick = 1'b0;
      end
      if (m_pwm == 0) m_dutyq = int'(duty);
      m_pwm = (m_pwm + 1) % 256;
      e_led = nl;
    end else begin
      e_tick = 1'b0;
    end
  end

  always @(negedge clk0) begin
    if (model_ok) begin
      chk("model_led", 32'(led), 32'(e_led));
      chk("model_tick", 32'(tick), 32'(e_tick));
    end
  end

  task automatic wait_tick(input string name);
    int i = 0;
    do begin
      @(negedge clk0);
      i++;
    end while (tick !== 1'b1 && i < 200);
    chk(name, 32'(tick), 1);
  endtask

  task automatic tick_latency(output int lat);
    lat = 0;
    do begin
      @(negedge clk0);
      lat++;
    end while (tick !== 1'b1 && lat < 50);
  endtask

  logic [3:0] scan_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
  int         pwm_duties [3] = '{0, 64, 255};

  initial begin
    int lat, on;
    rst = 1'b0; en = 1'b1; mode = 2'd0; duty = 8'd0;
    repeat (3) @(negedge clk0);
    chk("reset_led", 32'(led), 0);
    chk("reset_tick", 32'(tick), 0);

    // binary count
    rst = 1'b1;
    tick_latency(lat);
    chk("first_tick_latency", lat, PD);
    @(negedge clk0);
    chk("bin_led_1", 32'(led), 1);
    for (int k = 2; k <= 16; k++) begin
      wait_tick("bin_tick");
      @(negedge clk0);
      chk("bin_led", 32'(led), k % 16);
    end

    // freeze with en=0 mid-count
    wait_tick("bin_tick");
    @(negedge clk0);
    chk("pre_freeze_led", 32'(led), 1);
    en = 1'b0;
    repeat (10) begin
      @(negedge clk0);
      chk("freeze_led", 32'(led), 1);
      chk("freeze_tick", 32'(tick), 0);
    end
    en = 1'b1;
    tick_latency(lat);
    chk("resume_tick_latency", lat, 3);
    @(negedge clk0);
    chk("resume_led", 32'(led), 2);

    // scanner
    mode = 2'd1;
    repeat (2) @(negedge clk0);
    chk("scan_led_0", 32'(led), 32'(scan_exp[0]));
    for (int k = 1; k < 8; k++) begin
      wait_tick("scan_tick");
      @(negedge clk0);
      chk("scan_led", 32'(led), 32'(scan_exp[k]));
    end

    // mode change coinciding with prescaler at PD-1
    wait_tick("scan_tick");
    repeat (3) @(negedge clk0);
    mode = 2'd0;
    @(negedge clk0);
    chk("clear_no_tick", 32'(tick), 0);
    @(negedge clk0);
    chk("clear_led", 32'(led), 0);

    // reset mid-scan
    mode = 2'd1;
    wait_tick("scan_tick");
    wait_tick("scan_tick");
    @(negedge clk0);
    chk("scan_before_reset", 32'(led), 32'(4'b0100));
    rst = 1'b0; mode = 2'd0;
    @(negedge clk0);
    chk("rst_led", 32'(led), 0);
    chk("rst_tick", 32'(tick), 0);
    rst = 1'b1;
    tick_latency(lat);
    chk("rst_first_tick_latency", lat, PD);
    @(negedge clk0);
    chk("rst_led_after", 32'(led), 1);

    // PWM duty boundaries
    mode = 2'd2;
    for (int j = 0; j < 3; j++) begin
      duty = 8'(pwm_duties[j]);
      repeat (300) @(negedge clk0);
      on = 0;
      repeat (256) begin
        @(negedge clk0);
        if (led == 4'hF) on++;
      end
      chk("pwm_on_cycles", on, pwm_duties[j]);
    end

    // breathe
    mode = 2'd3;
`ifdef LED_PATTERN_BREATHE_EN
    for (int k = 0; k < 255; k++) wait_tick("breathe_tick");
    chk("breathe_top", 32'(dut.br_duty), 255);
    for (int k = 0; k < 255; k++) wait_tick("breathe_tick");
    chk("breathe_bottom", 32'(dut.br_duty), 0);
`else
    repeat (2) @(negedge clk0);
    repeat (64) begin
      @(negedge clk0);
      chk("breathe_off_led", 32'(led), 0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach summary, n_bad=%0d", n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule
